lb_byte_bridge: RTL and testbench
=================================

// Module: lb_byte_bridge
// PURPOSE
//  Host-link bridge driving the SUMP2 core's LocalBus from an 8-bit byte stream (UART RX/TX).
//  Parses write/read/burst-read command packets into single-cycle lb_wr/lb_rd strobes.
//  Read data returns MSB-first on the TX byte interface.
//  Sits between the UART and the core wrapper; everything runs on clk_lb.
// PARAMETERS
//  rd_timeout    16'd255    clk_lb cycles to wait for lb_rd_rdy before substituting rd_fill
//  pkt_timeout   24'd480000 idle clk_lb cycles mid-packet before the parser abandons it
//  rd_fill       32'hDEADBEEF  data returned on a read timeout
// PORTS
//  clk_lb        in   1   sole clock
//  reset_n       in   1   synchronous, active-low reset
//  rx_byte       in   8   received byte, valid with rx_valid
//  rx_valid      in   1   one-cycle strobe per byte; no backpressure
//  tx_byte       out  8   byte to transmit
//  tx_valid      out  1   tx_byte valid; held until tx_ready
//  tx_ready      in   1   TX accepts byte when tx_valid & tx_ready
//  lb_wr         out  1   one-cycle write strobe
//  lb_rd         out  1   one-cycle read strobe
//  lb_addr       out  32  bus address, held stable from strobe until return to IDLE
//  lb_wr_d       out  32  write data, valid with lb_wr
//  lb_rd_d       in   32  read data, valid with lb_rd_rdy
//  lb_rd_rdy     in   1   read-data-valid strobe from slave
//  busy          out  1   1 whenever state != IDLE
//  err_pulse     out  1   one-cycle pulse: read timeout, dropped RX byte or packet timeout
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE; all outputs 0; all counters 0.
//   Applies mid-packet or mid-read with no TX completion.
//  Packet format, multi-byte fields MSB first:
//   0xA0 = write: op, addr[4], data[4].
//   0xA1 = read: op, addr[4].
//   0xA2 = burst read: op, addr[4], cnt[1]; N=cnt, cnt=0 means 256 reads at the same address.
//   Any other op byte in IDLE is discarded silently.
//  States: IDLE -> ADDR(4 bytes) -> {DATA(4) | CNT(1) | -} -> WR | RD -> RD_WAIT -> TX(4) -> IDLE.
//   After TX, a burst with reads remaining goes back to RD instead of IDLE.
//  WR: lb_wr=1 for exactly one cycle, in the cycle after the last data byte is accepted;
//   then IDLE.
//  RD: lb_rd=1 for exactly one cycle, in the cycle after the last addr/cnt byte;
//   burst re-reads issue lb_rd the cycle after the last TX byte handshakes.
//  RD_WAIT: entered the cycle after lb_rd. lb_rd_rdy is sampled only here;
//   lb_rd_rdy in any other state is ignored.
//   First rdy captures lb_rd_d into the shift register.
//   The wait counter counts from 1. Reaching rd_timeout without rdy captures rd_fill and pulses err_pulse.
//   rdy in the same cycle as the terminal count wins: data taken, no error.
//  TX: tx_byte = shreg[31:24]; shift left 8 on each handshake; 4 handshakes, then next state.
//   tx_valid rises the cycle after capture and never drops without a handshake.
//  rx_valid while state in {WR, RD, RD_WAIT, TX}: byte dropped, err_pulse=1; no state change.
//  Packet timer clears on every accepted byte.
//   In ADDR/DATA/CNT, pkt_timeout cycles with no rx_valid -> IDLE, err_pulse=1, no bus strobe.
//  lb_addr/lb_wr_d load byte-wise as bytes arrive. lb_wr and lb_rd are never high together.
//  Burst counter is 9 bits: loaded with cnt (0 -> 256) and decremented per lb_rd.
// TESTING
//  1. Bytes A0 00 00 00 00 00 00 00 05 -> a single lb_wr, addr 0x0, wr_d 0x00000005, on the cycle after byte 9; no TX.
//  2. Bytes A1 00 00 00 04; slave rdy 2 cycles after lb_rd with 0x12345678 -> TX 12 34 56 78; tx_ready stalls hold tx_byte stable.
//  3. Bytes A1 addr 0x4; slave never answers -> after 255 wait cycles, err_pulse=1 and TX DE AD BE EF; rdy on cycle 255 -> real data, no error.
//  4. Bytes A2 00 00 00 04 03 -> 3 lb_rd pulses at 0x4, 12 TX bytes in read order; cnt=00 -> 256 reads, 1024 bytes.
//  5. Bytes A0 00 00, then idle for pkt_timeout -> err_pulse, IDLE, no lb_wr; next full packet executes normally.
//  6. reset_n low mid-TX; RX byte during RD_WAIT; op 0x55 -> all outputs 0 at next edge; err_pulse with no state change; op 0x55 ignored.

Source files
------------

// File: rtl/lb_byte_bridge.sv
// Byte-stream to LocalBus bridge: parses write/read/burst-read packets from the
// UART RX stream into single-cycle bus strobes and returns read data MSB-first on TX.
module lb_byte_bridge #(
  parameter logic [15:0] rd_timeout  = 16'd255,
  parameter logic [23:0] pkt_timeout = 24'd480000,
  parameter logic [31:0] rd_fill     = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        busy,
  output logic        err_pulse
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CNT, S_WR, S_RD, S_RD_WAIT, S_TX
  } state_e;

  localparam logic [7:0] OP_WR    = 8'hA0;
  localparam logic [7:0] OP_RD    = 8'hA1;
  localparam logic [7:0] OP_BURST = 8'hA2;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [8:0]  burst_q, burst_d;
  logic [15:0] wait_q, wait_d;
  logic [23:0] pkt_q, pkt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        err_q, err_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    burst_d    = burst_q;
    wait_d     = wait_q;
    pkt_d      = pkt_q;
    shreg_d    = shreg_q;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_byte == OP_WR || rx_byte == OP_RD || rx_byte == OP_BURST)) begin
          op_d       = rx_byte[1:0];
          byte_cnt_d = 2'd0;
          pkt_d      = 24'd0;
          state_d    = S_ADDR;
        end
      end

      S_ADDR, S_DATA, S_CNT: begin
        if (rx_valid) begin
          pkt_d      = 24'd0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_ADDR) begin
            addr_d = {addr_q[23:0], rx_byte};
            if (byte_cnt_q == 2'd3) begin
              unique case (op_q)
                2'd0:    state_d = S_DATA;
                2'd1:    begin burst_d = 9'd1; state_d = S_RD; end
                default: state_d = S_CNT;
              endcase
            end
          end else if (state_q == S_DATA) begin
            wr_data_d = {wr_data_q[23:0], rx_byte};
            if (byte_cnt_q == 2'd3) state_d = S_WR;
          end else begin
            // A zero count byte means a full 256-read burst.
            burst_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
            state_d = S_RD;
          end
        end else if (pkt_q == pkt_timeout - 24'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          pkt_d = pkt_q + 24'd1;
        end
      end

      S_WR: state_d = S_IDLE;

      S_RD: begin
        burst_d = burst_q - 9'd1;
        wait_d  = 16'd1;
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        byte_cnt_d = 2'd0;
        if (lb_rd_rdy) begin
          shreg_d = lb_rd_d;
          state_d = S_TX;
        end else if (wait_q == rd_timeout) begin
          shreg_d = rd_fill;
          err_d   = 1'b1;
          state_d = S_TX;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      S_TX: begin
        if (tx_ready) begin
          shreg_d    = {shreg_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = (burst_q != 9'd0) ? S_RD : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // RX has no backpressure: bytes arriving while a bus transaction is in flight are lost.
    if (rx_valid && (state_q == S_WR || state_q == S_RD || state_q == S_RD_WAIT || state_q == S_TX))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_lb) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      byte_cnt_q <= 2'd0;
      addr_q     <= 32'd0;
      wr_data_q  <= 32'd0;
      burst_q    <= 9'd0;
      wait_q     <= 16'd0;
      pkt_q      <= 24'd0;
      shreg_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      burst_q    <= burst_d;
      wait_q     <= wait_d;
      pkt_q      <= pkt_d;
      shreg_q    <= shreg_d;
      err_q      <= err_d;
    end
  end

  assign lb_wr     = (state_q == S_WR);
  assign lb_rd     = (state_q == S_RD);
  assign busy      = (state_q != S_IDLE);
  assign tx_valid  = (state_q == S_TX);
  assign tx_byte   = tx_valid ? shreg_q[31:24] : 8'h00;
  assign lb_addr   = addr_q;
  assign lb_wr_d   = wr_data_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_lb_byte_bridge.sv
// Self-checking bench for lb_byte_bridge: random packets, a slave with random
// response latency, and a queue-based model of expected bus and TX traffic.
module tb_lb_byte_bridge;

  localparam logic [23:0] PKT_TO = 24'd100;
  localparam int          RD_TO  = 255;
  localparam logic [31:0] FILL   = 32'hDEADBEEF;

  logic        clk_lb = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        lb_wr, lb_rd;
  logic [31:0] lb_addr, lb_wr_d, lb_rd_d;
  logic        lb_rd_rdy;
  logic        busy, err_pulse;

  lb_byte_bridge #(.rd_timeout(16'd255), .pkt_timeout(PKT_TO), .rd_fill(FILL)) dut (
    .clk_lb(clk_lb), .reset_n(reset_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
    .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk_lb = ~clk_lb;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed traffic and model expectations
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [63:0] wr_q[$];
  logic [31:0] rd_addr_q[$];
  int          err_seen = 0;
  int          exp_err  = 0;

  // Slave / TX-sink behaviour knobs
  int          dly_min = 1, dly_max = 1;
  bit          data_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  bit          stall_en = 1'b0;
  bit          force_stall = 1'b0;

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
  initial begin
    logic [7:0] prev_byte;
    bit         prev_stall;
    prev_stall = 1'b0;
    prev_byte  = 8'h0;
    forever begin
      @(negedge clk_lb);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx_hold_valid", tx_valid, 1);
          check("tx_hold_byte", tx_byte, prev_byte);
        end
        if (lb_wr || lb_rd) check("wr_rd_excl", lb_wr & lb_rd, 0);
        if (lb_wr) wr_q.push_back({lb_addr, lb_wr_d});
        if (lb_rd) rd_addr_q.push_back(lb_addr);
        if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
        if (err_pulse) err_seen++;
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
      end
    end
  end

  // Slave model: answers each lb_rd after d cycles; predicts what the bridge must send.
  initial begin
    int          d;
    logic [31:0] data, v;
    lb_rd_rdy = 1'b0;
    lb_rd_d   = 32'h0;
    forever begin
      @(negedge clk_lb);
      if (reset_n && lb_rd) begin
        d    = int'($urandom_range(dly_max, dly_min));
        data = data_fixed ? fixed_data : $urandom;
        v    = (d <= RD_TO) ? data : FILL;
        if (d > RD_TO) exp_err++;
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(v[8*i +: 8]);
        repeat (d) @(posedge clk_lb);
        #1 lb_rd_rdy = 1'b1; lb_rd_d = data;
        @(posedge clk_lb);
        #1 lb_rd_rdy = 1'b0; lb_rd_d = $urandom;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk_lb);
      #1 tx_ready = force_stall ? 1'b0 : (stall_en ? 1'($urandom_range(1, 0)) : 1'b1);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk_lb);
    #1 rx_valid = 1'b1; rx_byte = b;
    @(posedge clk_lb);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [31:0] a);
    send(op);
    for (int i = 3; i >= 0; i--) send(a[8*i +: 8]);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    @(negedge clk_lb);
    while (busy && n < max_cycles) begin
      @(negedge clk_lb);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_txb"}, tx_byte, 0);
    check({tag, "_wr"}, lb_wr, 0);
    check({tag, "_rd"}, lb_rd, 0);
    check({tag, "_addr"}, lb_addr, 0);
    check({tag, "_wrd"}, lb_wr_d, 0);
    check({tag, "_err"}, err_pulse, 0);
  endtask

  task automatic check_tx(input string tag);
    check({tag, "_len"}, tx_q.size(), exp_tx_q.size());
    for (int i = 0; i < tx_q.size() && i < exp_tx_q.size(); i++)
      check({tag, "_byte"}, tx_q[i], exp_tx_q[i]);
    tx_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic check_reads(input string tag, input int n, input logic [31:0] a);
    check({tag, "_rdcnt"}, rd_addr_q.size(), n);
    foreach (rd_addr_q[i]) check({tag, "_rdaddr"}, rd_addr_q[i], a);
    rd_addr_q.delete();
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    send_pkt(8'hA0, a);
    for (int i = 3; i >= 0; i--) send(d[8*i +: 8]);
    @(negedge clk_lb);
    check({tag, "_strobe"}, lb_wr, 1);
    wait_idle(20);
    check({tag, "_wrcnt"}, wr_q.size(), 1);
    if (wr_q.size() > 0) check({tag, "_wrval"}, wr_q[0], {a, d});
    wr_q.delete();
    check({tag, "_notx"}, tx_q.size(), 0);
  endtask

  initial begin
    logic [31:0] a, d;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h0;
    repeat (3) @(posedge clk_lb);
    @(negedge clk_lb);
    check_zero_outputs("reset");
    @(posedge clk_lb);
    #1 reset_n = 1'b1;

    // Single write, then random writes
    do_write("wr0", 32'h0, 32'h5);
    for (int i = 0; i < 4; i++) do_write("wr_rand", $urandom, $urandom);

    // Single read with slave latency 2 and a stalling TX sink
    data_fixed = 1'b1; fixed_data = 32'h12345678;
    dly_min = 2; dly_max = 2; stall_en = 1'b1;
    send_pkt(8'hA1, 32'h4);
    wait_idle(200);
    check_reads("rd", 1, 32'h4);
    check_tx("rd_tx");
    check("rd_err", err_seen, exp_err);
    stall_en = 1'b0; data_fixed = 1'b0;

    // Read timeout: slave far too late, then exactly at the terminal count
    dly_min = 300; dly_max = 300;
    send_pkt(8'hA1, 32'h4);
    wait_idle(400);
    repeat (60) @(negedge clk_lb);
    check_tx("to_tx");
    check("to_err", err_seen, exp_err);
    dly_min = RD_TO; dly_max = RD_TO;
    send_pkt(8'hA1, 32'h4);
    wait_idle(400);
    check_tx("to255_tx");
    check("to255_err", err_seen, exp_err);
    check_reads("to", 2, 32'h4);

    // Bursts: 3 reads with random latency and stalls, then cnt=0 (256 reads)
    dly_min = 1; dly_max = 20; stall_en = 1'b1;
    a = $urandom;
    send_pkt(8'hA2, a); send(8'h03);
    wait_idle(2000);
    check_reads("b3", 3, a);
    check_tx("b3_tx");
    dly_min = 1; dly_max = 3; stall_en = 1'b0;
    send_pkt(8'hA2, 32'h4); send(8'h00);
    wait_idle(5000);
    check_reads("b256", 256, 32'h4);
    check_tx("b256_tx");
    check("burst_err", err_seen, exp_err);

    // Packet timeout mid-write, then a normal write
    send(8'hA0); send(8'h00); send(8'h00);
    repeat (int'(PKT_TO) - 10) @(negedge clk_lb);
    check("pkt_still_busy", busy, 1);
    repeat (20) @(negedge clk_lb);
    check("pkt_to_idle", busy, 0);
    exp_err++;
    check("pkt_to_err", err_seen, exp_err);
    check("pkt_to_nowr", wr_q.size(), 0);
    do_write("wr_after_to", $urandom, $urandom);

    // RX byte dropped during RD_WAIT; read still completes
    dly_min = 20; dly_max = 20;
    send_pkt(8'hA1, 32'h8);
    repeat (3) @(negedge clk_lb);
    send(8'h33);
    @(negedge clk_lb);
    check("drop_busy", busy, 1);
    exp_err++;
    wait_idle(100);
    check_reads("drop", 1, 32'h8);
    check_tx("drop_tx");
    check("drop_err", err_seen, exp_err);

    // Unknown op ignored
    send(8'h55);
    @(negedge clk_lb);
    check("op55_idle", busy, 0);
    send(8'h00);
    @(negedge clk_lb);
    check("op55_idle2", busy, 0);
    check("op55_err", err_seen, exp_err);

    // Reset mid-TX
    dly_min = 2; dly_max = 2; force_stall = 1'b1;
    send_pkt(8'hA1, 32'hC);
    begin
      int n = 0;
      while (!tx_valid && n < 100) begin @(negedge clk_lb); n++; end
    end
    check("rst_tx_reached", tx_valid, 1);
    @(posedge clk_lb);
    #1 reset_n = 1'b0;
    @(negedge clk_lb);
    @(negedge clk_lb);
    check_zero_outputs("midrst");
    @(posedge clk_lb);
    #1 reset_n = 1'b1; force_stall = 1'b0;
    tx_q.delete(); exp_tx_q.delete(); rd_addr_q.delete();
    check("midrst_err", err_seen, exp_err);

    // Normal read after reset
    dly_min = 1; dly_max = 10;
    d = $urandom;
    send_pkt(8'hA1, d);
    wait_idle(100);
    check_reads("post_rst", 1, d);
    check_tx("post_rst_tx");
    check("final_err", err_seen, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
